// File: rtl/ssd_sign_mag_scan_pkg.sv
// Shared definitions for the sign/magnitude 7-segment scanner:
// display polarity, segment codes and the converter state encoding.
package ssd_sign_mag_scan_pkg;

  // Anodes and cathodes are both driven low to light.
  localparam logic AN_ON  = 1'b0;
  localparam logic AN_OFF = 1'b1;

  // Segment codes, active-low, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Converter: idle, or shifting one bit per clock.
  typedef enum logic {
    CONV_IDLE  = 1'b0,
    CONV_SHIFT = 1'b1
  } conv_state_t;

  // BCD digit to segment code; non-decimal codes show blank.
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    seg_digit = SEG_0;
      4'd1:    seg_digit = SEG_1;
      4'd2:    seg_digit = SEG_2;
      4'd3:    seg_digit = SEG_3;
      4'd4:    seg_digit = SEG_4;
      4'd5:    seg_digit = SEG_5;
      4'd6:    seg_digit = SEG_6;
      4'd7:    seg_digit = SEG_7;
      4'd8:    seg_digit = SEG_8;
      4'd9:    seg_digit = SEG_9;
      default: seg_digit = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble (shift-add-3) binary to BCD converter.
// start loads bin; N shift clocks follow; bcd is updated and done pulses
// on the last shift. A start while busy restarts from the new value.
// busy mirrors the FSM state (high while shifting).
module bin2bcd_seq
  import ssd_sign_mag_scan_pkg::*;
#(
  parameter int N    = 4,
  parameter int NDIG = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N-1:0]      bin,
  output logic [4*NDIG-1:0] bcd,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  conv_state_t       state_q, state_d;
  logic [N-1:0]      bin_sr;
  logic [4*NDIG-1:0] bcd_sr;
  logic [4*NDIG-1:0] adj;
  logic [4*NDIG-1:0] shifted;
  logic [CW-1:0]     cnt;

  // Next state: leave SHIFT after the N-th shift unless restarted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CONV_IDLE:  if (start) state_d = CONV_SHIFT;
      CONV_SHIFT: if (!start && cnt == LAST) state_d = CONV_IDLE;
    endcase
  end

  // Add 3 to every BCD digit >= 5, then shift in the next binary MSB.
  always_comb begin
    adj = bcd_sr;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end
    shifted = {adj[4*NDIG-2:0], bin_sr[N-1]};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= CONV_IDLE;
    else     state_q <= state_d;
  end

  // Shift registers, step counter and result/done outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_sr <= '0;
      bcd_sr <= '0;
      cnt    <= '0;
      bcd    <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        bin_sr <= bin;
        bcd_sr <= '0;
        cnt    <= '0;
      end else if (state_q == CONV_SHIFT) begin
        bin_sr <= bin_sr << 1;
        bcd_sr <= shifted;
        cnt    <= cnt + CW'(1);
        if (cnt == LAST) begin
          bcd  <= shifted;
          done <= 1'b1;
        end
      end
    end
  end

  assign busy = (state_q == CONV_SHIFT);

endmodule

// File: rtl/ssd_sign_mag_scan.sv
// Multiplexed 7-segment driver for a sign/magnitude/overflow result.
// Inputs are sampled once per scan frame (when the sign digit slot starts),
// converted to BCD in the background and committed at the frame wrap, so a
// frame always shows one coherent value. Leading zeros are blanked, negative
// values get '-', overflow shows a blinking "Err".
module ssd_sign_mag_scan
  import ssd_sign_mag_scan_pkg::*;
#(
  parameter int N            = 4,
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      mag,
  input  logic              sign,
  input  logic              ovf,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              dp
);

  localparam int NDIG = DIGITS - 1;
  localparam int RW   = $clog2(REFRESH_DIV);
  localparam int IW   = $clog2(DIGITS + 1);
  localparam int FW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [RW-1:0]     refresh_cnt;
  logic [IW-1:0]     idx;
  logic              tick, last_idx, capture, wrap;

  logic [N-1:0]      sh_mag;
  logic              sh_sign, sh_ovf;

  logic [4*NDIG-1:0] conv_bcd, res_bcd;
  logic              conv_busy, conv_done;

  logic [4*NDIG-1:0] disp_bcd;
  logic              disp_neg, disp_ovf;
  logic [FW-1:0]     frame_cnt;
  logic              blink;

  logic [NDIG-1:0]   lz;
  logic [3:0]        cur_digit;
  logic              cur_lz, lit;
  logic [6:0]        seg_d;
  logic [DIGITS-1:0] an_d;

  assign tick     = (refresh_cnt == RW'(REFRESH_DIV - 1));
  assign last_idx = (idx == IW'(DIGITS - 1));
  assign capture  = tick && (idx == IW'(DIGITS - 2));
  assign wrap     = tick && last_idx;
  assign dp       = 1'b1;

  // Refresh divider and digit slot index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
      idx         <= '0;
    end else if (tick) begin
      refresh_cnt <= '0;
      idx         <= last_idx ? '0 : idx + IW'(1);
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  // Sample the inputs as the sign slot begins; the converter starts on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_mag  <= '0;
      sh_sign <= 1'b0;
      sh_ovf  <= 1'b0;
    end else if (capture) begin
      sh_mag  <= mag;
      sh_sign <= sign;
      sh_ovf  <= ovf;
    end
  end

  bin2bcd_seq #(
    .N    (N),
    .NDIG (NDIG)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (capture),
    .bin   (mag),
    .bcd   (conv_bcd),
    .busy  (conv_busy),
    .done  (conv_done)
  );

  // Hold the finished conversion until the frame wrap picks it up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            res_bcd <= '0;
    else if (conv_done) res_bcd <= conv_bcd;
  end

  // Commit at the frame wrap and advance the overflow blink phase.
  // A still-running conversion skips the commit so digits and sign never mismatch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_bcd  <= '0;
      disp_neg  <= 1'b0;
      disp_ovf  <= 1'b0;
      frame_cnt <= '0;
      blink     <= 1'b0;
    end else if (wrap && !conv_busy) begin
      disp_bcd <= res_bcd;
      disp_neg <= sh_sign && (sh_mag != '0);
      disp_ovf <= sh_ovf;
      if (!sh_ovf) begin
        frame_cnt <= '0;
        blink     <= 1'b0;
      end else if (disp_ovf) begin
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          blink     <= ~blink;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end

  // Leading-zero flags: lz[i] is set when BCD digit i and all above it are zero.
  always_comb begin
    lz = '0;
    lz[NDIG-1] = (disp_bcd[4*NDIG-1 -: 4] == 4'd0);
    for (int i = NDIG - 2; i >= 0; i--) begin
      lz[i] = lz[i+1] && (disp_bcd[4*i +: 4] == 4'd0);
    end
  end

  // Pick the content of the current slot and encode it.
  always_comb begin
    cur_digit = 4'd0;
    cur_lz    = 1'b1;
    seg_d     = SEG_BLANK;
    lit       = 1'b0;
    an_d      = {DIGITS{AN_OFF}};
    for (int i = 0; i < NDIG; i++) begin
      if (idx == IW'(i)) begin
        cur_digit = disp_bcd[4*i +: 4];
        cur_lz    = lz[i];
      end
    end
    if (disp_ovf) begin
      if (idx == IW'(2)) begin
        seg_d = SEG_E;
        lit   = 1'b1;
      end else if (idx == IW'(1) || idx == '0) begin
        seg_d = SEG_R;
        lit   = 1'b1;
      end
    end else if (last_idx) begin
      if (disp_neg) begin
        seg_d = SEG_MINUS;
        lit   = 1'b1;
      end
    end else if (idx == '0 || !cur_lz) begin
      seg_d = seg_digit(cur_digit);
      lit   = 1'b1;
    end
    if (blink) begin
      seg_d = SEG_BLANK;
      lit   = 1'b0;
    end
    for (int i = 0; i < DIGITS; i++) begin
      an_d[i] = (lit && idx == IW'(i)) ? AN_ON : AN_OFF;
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= {DIGITS{AN_OFF}};
      seg <= SEG_BLANK;
    end else begin
      an  <= an_d;
      seg <= seg_d;
    end
  end

endmodule

// File: tb/tb_ssd_sign_mag_scan.sv
// Bench for ssd_sign_mag_scan (N=8, DIGITS=4, REFRESH_DIV=16, BLINK_FRAMES=2).
// A frame is 64 clocks; each slot is sampled on the falling edge mid-slot.
// Expected {an,seg} per slot is pushed to exp_q when the input is driven and
// popped when the corresponding frame is observed.
module tb_ssd_sign_mag_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] mag = 8'd0;
  logic       sign = 1'b0;
  logic       ovf = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int failures = 0;
  int k;
  int chg_slot = -1;
  logic [7:0] chg_mag = 8'd0;

  logic [10:0] exp_q[$];
  logic [10:0] obs[4];
  logic [6:0]  seg_tab[10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  ssd_sign_mag_scan #(
    .N            (8),
    .DIGITS       (4),
    .REFRESH_DIV  (16),
    .BLINK_FRAMES (2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .mag  (mag),
    .sign (sign),
    .ovf  (ovf),
    .an   (an),
    .seg  (seg),
    .dp   (dp)
  );

  // Clock and bench-side clock count since reset release.
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  // Reference for one slot of a normal-mode frame.
  function automatic logic [10:0] model_slot(input int m, input logic s, input int slot);
    logic [10:0] r;
    r = {4'b1111, 7'b1111111};
    case (slot)
      0:       r = {4'b1110, seg_tab[m % 10]};
      1:       if (m >= 10)  r = {4'b1101, seg_tab[(m / 10) % 10]};
      2:       if (m >= 100) r = {4'b1011, seg_tab[(m / 100) % 10]};
      default: if (s && m != 0) r = {4'b0111, 7'b0111111};
    endcase
    return r;
  endfunction

  // Reference for one slot of an overflow frame.
  function automatic logic [10:0] model_err(input int slot, input logic dark);
    logic [10:0] r;
    r = {4'b1111, 7'b1111111};
    if (!dark) begin
      case (slot)
        0:       r = {4'b1110, 7'b0101111};
        1:       r = {4'b1101, 7'b0101111};
        2:       r = {4'b1011, 7'b0000110};
        default: r = {4'b1111, 7'b1111111};
      endcase
    end
    return r;
  endfunction

  task automatic push_frame(input int m, input logic s);
    for (int i = 0; i < 4; i++) exp_q.push_back(model_slot(m, s, i));
  endtask

  task automatic push_err(input logic dark);
    for (int i = 0; i < 4; i++) exp_q.push_back(model_err(i, dark));
  endtask

  // Sample the four slots of the next frame into obs[]; optionally change mag after a slot.
  task automatic capture_frame();
    int guard;
    for (int s = 0; s < 4; s++) begin
      guard = 0;
      @(negedge clk);
      while ((k % 64) != (16 * s + 8) && guard < 300) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 300) begin
        checks++;
        failures++;
        $display("FAIL frame_sync slot%0d: k=%0d, sample point not reached", s, k);
      end
      obs[s] = {an, seg};
      if (s == chg_slot) begin
        mag = chg_mag;
        chg_slot = -1;
      end
    end
  endtask

  task automatic test_reset();
    logic [10:0] e;
    int guard;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (an !== 4'b1111) begin failures++; $display("FAIL reset_an: got %b want 1111", an); end
    checks++;
    if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg: got %b want 1111111", seg); end
    checks++;
    if (dp !== 1'b1) begin failures++; $display("FAIL reset_dp: got %b want 1", dp); end
    @(negedge clk);
    rst = 1'b0;
    push_frame(0, 1'b0);
    capture_frame();
    for (int s = 0; s < 4; s++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs[s] !== e) begin
        failures++;
        $display("FAIL reset_frame0 slot%0d: an=%b seg=%b, want an=%b seg=%b", s, obs[s][10:7], obs[s][6:0], e[10:7], e[6:0]);
      end
    end
    // Mid-frame reset while the ones digit is lit.
    guard = 0;
    @(negedge clk);
    while ((k % 64) != 8 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if ({an, seg} !== {4'b1110, 7'b1000000}) begin
      failures++;
      $display("FAIL pre_reset_slot0: an=%b seg=%b, want an=1110 seg=1000000", an, seg);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (an !== 4'b1111) begin failures++; $display("FAIL midreset_an: got %b want 1111", an); end
    checks++;
    if (seg !== 7'h7F) begin failures++; $display("FAIL midreset_seg: got %b want 1111111", seg); end
    checks++;
    if (dp !== 1'b1) begin failures++; $display("FAIL midreset_dp: got %b want 1", dp); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_frame(0, 1'b0);
    capture_frame();
    for (int s = 0; s < 4; s++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs[s] !== e) begin
        failures++;
        $display("FAIL reset_mid_frame0 slot%0d: an=%b seg=%b, want an=%b seg=%b", s, obs[s][10:7], obs[s][6:0], e[10:7], e[6:0]);
      end
    end
  endtask

  task automatic test_digits(input string name, input int m, input logic s_in);
    logic [10:0] e;
    mag = 8'(m);
    sign = s_in;
    push_frame(m, s_in);
    capture_frame();
    capture_frame();
    for (int s = 0; s < 4; s++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs[s] !== e) begin
        failures++;
        $display("FAIL %s slot%0d: an=%b seg=%b, want an=%b seg=%b", name, s, obs[s][10:7], obs[s][6:0], e[10:7], e[6:0]);
      end
    end
  endtask

  task automatic test_mid_change(input string name, input int m0, input int m1, input int slot);
    logic [10:0] e;
    mag = 8'(m0);
    sign = 1'b0;
    capture_frame();
    push_frame(m0, 1'b0);
    chg_slot = slot;
    chg_mag = 8'(m1);
    capture_frame();
    for (int s = 0; s < 4; s++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs[s] !== e) begin
        failures++;
        $display("FAIL %s_old slot%0d: an=%b seg=%b, want an=%b seg=%b", name, s, obs[s][10:7], obs[s][6:0], e[10:7], e[6:0]);
      end
    end
    push_frame(m1, 1'b0);
    capture_frame();
    for (int s = 0; s < 4; s++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs[s] !== e) begin
        failures++;
        $display("FAIL %s_new slot%0d: an=%b seg=%b, want an=%b seg=%b", name, s, obs[s][10:7], obs[s][6:0], e[10:7], e[6:0]);
      end
    end
  endtask

  task automatic test_reset_during_conv();
    logic [10:0] e;
    int guard;
    mag = 8'd9;
    sign = 1'b0;
    capture_frame();
    guard = 0;
    @(negedge clk);
    while ((k % 64) != 50 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    rst = 1'b1;
    mag = 8'd3;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_frame(0, 1'b0);
    push_frame(3, 1'b0);
    for (int f = 0; f < 2; f++) begin
      capture_frame();
      for (int s = 0; s < 4; s++) begin
        e = exp_q.pop_front();
        checks++;
        if (obs[s] !== e) begin
          failures++;
          $display("FAIL conv_reset_f%0d slot%0d: an=%b seg=%b, want an=%b seg=%b", f, s, obs[s][10:7], obs[s][6:0], e[10:7], e[6:0]);
        end
      end
    end
  endtask

  task automatic test_ovf();
    logic [10:0] e;
    mag = 8'd0;
    sign = 1'b0;
    ovf = 1'b1;
    capture_frame();
    for (int j = 0; j < 8; j++) begin
      push_err(((j / 2) % 2) == 1);
      capture_frame();
      for (int s = 0; s < 4; s++) begin
        e = exp_q.pop_front();
        checks++;
        if (obs[s] !== e) begin
          failures++;
          $display("FAIL ovf_f%0d slot%0d: an=%b seg=%b, want an=%b seg=%b", j, s, obs[s][10:7], obs[s][6:0], e[10:7], e[6:0]);
        end
      end
      if (j == 6) begin
        ovf = 1'b0;
        mag = 8'd42;
      end
    end
    push_frame(42, 1'b0);
    capture_frame();
    for (int s = 0; s < 4; s++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs[s] !== e) begin
        failures++;
        $display("FAIL ovf_clear slot%0d: an=%b seg=%b, want an=%b seg=%b", s, obs[s][10:7], obs[s][6:0], e[10:7], e[6:0]);
      end
    end
  endtask

  // A new value every frame; each shows two frames after it is driven.
  task automatic test_back_to_back();
    logic [10:0] e;
    int m;
    logic s_in;
    mag = 8'd255;
    sign = 1'b1;
    push_frame(255, 1'b1);
    capture_frame();
    for (int i = 0; i < 8; i++) begin
      if (i < 7) begin
        if (i == 0) begin
          m = 10;
          s_in = 1'b1;
        end else if (i == 1) begin
          m = 0;
          s_in = 1'b0;
        end else begin
          m = $urandom_range(0, 255);
          s_in = 1'($urandom_range(0, 1));
        end
        mag = 8'(m);
        sign = s_in;
        push_frame(m, s_in);
      end
      capture_frame();
      for (int s = 0; s < 4; s++) begin
        e = exp_q.pop_front();
        checks++;
        if (obs[s] !== e) begin
          failures++;
          $display("FAIL b2b_f%0d slot%0d: an=%b seg=%b, want an=%b seg=%b", i, s, obs[s][10:7], obs[s][6:0], e[10:7], e[6:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_digits("mag5", 5, 1'b0);
    test_digits("mag200_neg", 200, 1'b1);
    test_digits("neg_zero", 0, 1'b1);
    test_digits("mag109", 109, 1'b0);
    test_mid_change("chg_7_9", 7, 9, 1);
    test_mid_change("chg_47_93", 47, 93, 0);
    test_reset_during_conv();
    test_ovf();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
